// File: rtl/door_lock_pkg.sv
// Shared types and defaults for the door-lock serial path.
// Optional response timeout is enabled with `define DOOR_TX_TIMEOUT_EN.
package door_lock_pkg;

    localparam int unsigned DOOR_CODE_W       = 4;
    localparam int unsigned DOOR_RESP_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT,
        DONE
    } tx_state_e;

endpackage

// File: rtl/door_code_shifter.sv
// Parallel-load, MSB-first shift register with a bit counter and a last-bit flag.
// Does not depend on DOOR_TX_TIMEOUT_EN.
module door_code_shifter
    import door_lock_pkg::*;
#(
    parameter int unsigned CODE_W = DOOR_CODE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [CODE_W-1:0] code,
    output logic              next_bit,
    output logic              last
);

    localparam int unsigned CNT_W = $clog2(CODE_W);

    logic [CODE_W-1:0] sreg;
    logic [CNT_W-1:0]  cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= code;
            cnt  <= '0;
        end else if (shift) begin
            sreg <= {sreg[CODE_W-2:0], 1'b0};
            // Counter saturates on the last bit rather than wrapping.
            if (!last) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // The bit that will be on the line next cycle, so the caller can register it.
    assign next_bit = sreg[CODE_W-2];
    assign last     = (cnt == CNT_W'(CODE_W - 1));

endmodule

// File: rtl/door_code_tx.sv
// Serial code transmitter: shifts a code MSB-first to the lock and latches its verdict.
// Define DOOR_TX_TIMEOUT_EN to give up after RESP_TIMEOUT WAIT cycles without a verdict.
module door_code_tx
    import door_lock_pkg::*;
#(
    parameter int unsigned CODE_W       = DOOR_CODE_W,
    parameter int unsigned RESP_TIMEOUT = DOOR_RESP_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CODE_W-1:0] code,
    input  logic              unlock,
    input  logic              error,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              busy,
    output logic              done,
    output logic              granted,
    output logic              denied,
    output logic              timeout
);

    if (CODE_W < 2) begin : g_bad_code_w
        $error("door_code_tx: CODE_W must be at least 2");
    end
    if (RESP_TIMEOUT < 1) begin : g_bad_timeout
        $error("door_code_tx: RESP_TIMEOUT must be at least 1");
    end

    tx_state_e state;
    logic      load;
    logic      shift;
    logic      next_bit;
    logic      last;

    assign load  = (state == IDLE) && start;
    assign shift = (state == SHIFT);

    door_code_shifter #(
        .CODE_W (CODE_W)
    ) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift    (shift),
        .code     (code),
        .next_bit (next_bit),
        .last     (last)
    );

`ifdef DOOR_TX_TIMEOUT_EN
    localparam int unsigned TCNT_W = $clog2(RESP_TIMEOUT + 1);

    logic [TCNT_W-1:0] wait_cnt;
    logic              expired;

    // Held at zero outside WAIT so every WAIT visit starts counting from 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state != WAIT) begin
            wait_cnt <= '0;
        end else if (!expired) begin
            wait_cnt <= wait_cnt + TCNT_W'(1);
        end
    end

    assign expired = (wait_cnt == TCNT_W'(RESP_TIMEOUT));
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            granted   <= 1'b0;
            denied    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SHIFT;
                        ser_out   <= code[CODE_W-1];
                        ser_valid <= 1'b1;
                        busy      <= 1'b1;
                        granted   <= 1'b0;
                        denied    <= 1'b0;
                        timeout   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (last) begin
                        state     <= WAIT;
                        ser_out   <= 1'b0;
                        ser_valid <= 1'b0;
                    end else begin
                        ser_out <= next_bit;
                    end
                end
                WAIT: begin
                    // unlock beats error, and any verdict beats an expiring timeout.
                    if (unlock) begin
                        granted <= 1'b1;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else if (error) begin
                        denied <= 1'b1;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
`ifdef DOOR_TX_TIMEOUT_EN
                    else if (expired) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/door_code_tx.md
# door_code_tx

Serial code transmitter for the door-lock path. It accepts a parallel access code, shifts it MSB-first, one bit per clock, onto the serial line that feeds the lock's `in` input. It then waits for the lock's `unlock`/`error` verdict and reports a latched result to the requesting controller (keypad or fob logic).

## Interface
- `CODE_W`, 4: code length in bits; must be ≥ 2.
- `RESP_TIMEOUT`, 16: maximum cycles to wait for a verdict (used only with `DOOR_TX_TIMEOUT_EN`); must be ≥ 1.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request to send `code`. Accepted only when `busy`=0.
- `code` in CODE_W: code to transmit; sampled on the accepting edge.
- `unlock` in 1: verdict from lock, success.
- `error` in 1: verdict from lock, failure.
- `ser_out` out 1: serial code bit to the lock's `in`.
- `ser_valid` out 1: high while `ser_out` carries a code bit.
- `busy` out 1: transfer or verdict wait in progress.
- `done` out 1: one-cycle pulse when the result is latched.
- `granted` out 1: latched; lock answered `unlock`.
- `denied` out 1: latched; lock answered `error`.
- `timeout` out 1: latched; no verdict within `RESP_TIMEOUT`.

## Operation
- States: IDLE, SHIFT, WAIT, DONE.
- IDLE:
  - `ser_out`=0, `ser_valid`=0, `busy`=0.
  - `start`=1 loads `code` into the shift register, clears `granted`/`denied`/`timeout`, and moves to SHIFT.
- SHIFT:
  - `ser_out` = current MSB of the shift register; `ser_valid`=1; `busy`=1.
  - Register shifts left by one each cycle.
  - Bit counter runs 0..CODE_W-1. After bit CODE_W-1, move to WAIT.
- WAIT:
  - `ser_out`=0, `ser_valid`=0, `busy`=1.
  - `unlock`/`error` are sampled every cycle.
  - `unlock`=1 sets `granted` and moves to DONE. If `unlock` and `error` are both 1 in the same cycle, `unlock` wins.
  - Otherwise `error`=1 sets `denied` and moves to DONE.
  - Verdict inputs are ignored in every state except WAIT.
- DONE: `done`=1 for exactly one cycle; `busy`=1; next state IDLE.
- `start` while `busy`=1 is ignored; there is no queueing.
- Exactly one of `granted`/`denied`/`timeout` is set after a transfer. It holds until the next accepted `start` or reset.
- Reset asserted mid-transfer aborts immediately: state IDLE, and no partial result is reported.
- Counter widths are `$clog2(CODE_W)` and `$clog2(RESP_TIMEOUT+1)`. Counters never wrap; each is cleared on entry to its state.

## Timing
- Reset values: `ser_out`, `ser_valid`, `busy`, `done`, `granted`, `denied`, `timeout` all 0; state IDLE.
- Start accepted at edge E. Bit CODE_W-1 of `code` appears on `ser_out` during cycle E+1. The last bit appears during cycle E+CODE_W.
- WAIT begins at cycle E+CODE_W+1.
- Verdict seen in WAIT cycle W: result flag rises and DONE is entered at W+1, `done` pulses during W+1, IDLE from W+2.
- Minimum start-to-start spacing is CODE_W+3 cycles.
- All outputs are registered. No combinational path from input to output.

## Configuration
- `DOOR_TX_TIMEOUT_EN` defined:
  - A WAIT-cycle counter runs.
  - If RESP_TIMEOUT WAIT cycles pass with no verdict, `timeout` is set and the block goes to DONE.
  - A verdict arriving in the same cycle the count expires takes priority over timeout.
- Not defined:
  - WAIT persists until a verdict arrives.
  - `timeout` is tied to 0.
  - `RESP_TIMEOUT` is unused and the counter is not built.

## Structure
- Shared package `door_lock_pkg`:
  - state enum (IDLE/SHIFT/WAIT/DONE)
  - default code width constant `DOOR_CODE_W` = 4
  - default `DOOR_RESP_TIMEOUT` = 16
- One natural sub-module, `door_code_shifter`: parallel-load, MSB-first shift register with bit counter and `last` flag. The FSM, verdict capture and timeout logic stay in the top level.

## Test plan
- Reset low mid-SHIFT after 2 bits: all outputs 0 while low. After release, `start` with code 4'b1100 sends 1,1,0,0 cleanly.
- `code`=4'b1010, `start` pulse: `ser_out` is 1,0,1,0 on cycles E+1..E+4 with `ser_valid`=1. `unlock` driven 2 cycles into WAIT gives `granted`=1 and a single `done` pulse.
- `code`=4'b1001: lock raises `error`, giving `denied`=1, `granted`=0.
- `unlock` and `error` both high in the same WAIT cycle: `granted`=1, `denied`=0.
- With `DOOR_TX_TIMEOUT_EN`, `RESP_TIMEOUT`=16, no verdict: `timeout`=1 and `done` pulse exactly 17 cycles after WAIT entry. Without the macro, still busy at 100 cycles.
- `start` re-asserted during SHIFT and during WAIT: ignored, and the serial sequence is unchanged. A new `start` after `done` clears the previous result flag.
